// File: rtl/axis_video_rx_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream video receive front end.
package axis_video_rx_fifo_pkg;

  localparam int FDATA_W    = 32;
  localparam int LINE_W_DEF = 1280;

  typedef logic [FDATA_W-1:0] FDATA;

  typedef struct packed {
    FDATA data;
    logic sof;
    logic eol;
  } vbeat_t;

  // base is the beat count before this beat; a line must end exactly on beat line_w
  function automatic logic line_len_bad(input logic last, input logic [31:0] base,
                                        input logic [31:0] line_w);
    logic bad;
    if (last) begin
      bad = ((base + 32'd1) != line_w);
    end else begin
      bad = (base == (line_w - 32'd1));
    end
    return bad;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO whose head entry is held in its own register.
module axis_sync_fifo
  import axis_video_rx_fifo_pkg::*;
#(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_next
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             valid_r;

  // Next occupancy and next read position
  always_comb begin
    level_nxt_s  = level_r;
    rd_ptr_nxt_s = rd_ptr_r;
    case ({push, pop})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
    if (pop) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next head value; bypass the write data when it lands directly in the head slot
  always_comb begin
    head_nxt_s = head_r;
    if (level_nxt_s == '0) begin
      head_nxt_s = head_r;
    end else if (push && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage write port; entries need no reset because level gates their visibility
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      valid_r  <= (level_nxt_s != '0);
      head_r   <= head_nxt_s;
    end
  end

  assign head       = head_r;
  assign head_valid = valid_r;
  assign level      = level_r;
  assign level_next = level_nxt_s;

endmodule

// File: rtl/axis_video_rx_fifo.sv
// AXI4-Stream video slave: registered TREADY, FWFT beat buffer and sticky line-length/SOF checks.
module axis_video_rx_fifo
  import axis_video_rx_fifo_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  parameter  int LINE_W = LINE_W_DEF,
  localparam int LW     = $clog2(DEPTH + 1),
  localparam int CW     = $clog2(LINE_W + 1)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [DATA_W-1:0] TDATA,
  input  logic              TVALID,
  input  logic              TLAST,
  input  logic              TUSER,
  output logic              TREADY,
  input  logic              datapath_ready,
  output logic [DATA_W-1:0] rgb_out,
  output logic              rgb_sof,
  output logic              rgb_eol,
  output logic              rgb_valid,
  output logic [LW-1:0]     level,
  input  logic              err_clr,
  output logic              err_line_len,
  output logic              err_sof
);

  logic              tready_r;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W+1:0] head_s;
  logic              head_valid_s;
  logic [LW-1:0]     level_nxt_s;
  logic [CW-1:0]     pix_cnt_r;
  logic [CW-1:0]     pix_base_s;
  logic [CW-1:0]     pix_nxt_s;
  logic              sof_mid_s;
  logic              len_bad_s;
  logic              err_line_len_r;
  logic              err_sof_r;

  assign push_s = TVALID & tready_r;
  assign pop_s  = head_valid_s & datapath_ready;

  axis_sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .push       (push_s),
    .pop        (pop_s),
    .din        ({TDATA, TUSER, TLAST}),
    .head       (head_s),
    .head_valid (head_valid_s),
    .level      (level),
    .level_next (level_nxt_s)
  );

  // Line checker: a mid-line SOF restarts counting as if this beat opened a new line
  always_comb begin
    sof_mid_s  = TUSER && (pix_cnt_r != '0);
    pix_base_s = pix_cnt_r;
    if (sof_mid_s) begin
      pix_base_s = '0;
    end else begin
      pix_base_s = pix_cnt_r;
    end
    len_bad_s = line_len_bad(TLAST, 32'(pix_base_s), 32'(LINE_W));
    if (TLAST) begin
      pix_nxt_s = '0;
    end else if (pix_base_s >= CW'(LINE_W - 1)) begin
      pix_nxt_s = CW'(LINE_W);
    end else begin
      pix_nxt_s = pix_base_s + CW'(1);
    end
  end

  // Handshake register, pixel counter and sticky flags (a new error beats err_clr)
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tready_r       <= 1'b0;
      pix_cnt_r      <= '0;
      err_line_len_r <= 1'b0;
      err_sof_r      <= 1'b0;
    end else begin
      tready_r <= (level_nxt_s < LW'(DEPTH));
      if (push_s) begin
        pix_cnt_r <= pix_nxt_s;
      end
      err_line_len_r <= (push_s & len_bad_s) | (err_line_len_r & ~err_clr);
      err_sof_r      <= (push_s & sof_mid_s) | (err_sof_r & ~err_clr);
    end
  end

  assign TREADY       = tready_r;
  assign rgb_out      = head_s[DATA_W+1:2];
  assign rgb_sof      = head_s[1];
  assign rgb_eol      = head_s[0];
  assign rgb_valid    = head_valid_s;
  assign err_line_len = err_line_len_r;
  assign err_sof      = err_sof_r;

endmodule

// File: tb/tb_axis_video_rx_fifo.sv
// Directed and randomized bench for axis_video_rx_fifo against a queue-based reference model.
module tb_axis_video_rx_fifo;

  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int LINE_W = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [DW-1:0] TDATA;
  logic          TVALID;
  logic          TLAST;
  logic          TUSER;
  logic          TREADY;
  logic          datapath_ready;
  logic [DW-1:0] rgb_out;
  logic          rgb_sof;
  logic          rgb_eol;
  logic          rgb_valid;
  logic [2:0]    level;
  logic          err_clr;
  logic          err_line_len;
  logic          err_sof;

  axis_video_rx_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .TDATA          (TDATA),
    .TVALID         (TVALID),
    .TLAST          (TLAST),
    .TUSER          (TUSER),
    .TREADY         (TREADY),
    .datapath_ready (datapath_ready),
    .rgb_out        (rgb_out),
    .rgb_sof        (rgb_sof),
    .rgb_eol        (rgb_eol),
    .rgb_valid      (rgb_valid),
    .level          (level),
    .err_clr        (err_clr),
    .err_line_len   (err_line_len),
    .err_sof        (err_sof)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of {data, sof, eol} plus a plain beat counter per line
  logic [DW+1:0] q_m[$];
  logic          tready_m = 1'b0;
  int            cnt_m    = 0;
  logic          eline_m  = 1'b0;
  logic          esof_m   = 1'b0;

  int            dut_acc;
  logic [DW-1:0] out_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic u,
                       input logic r, input logic c, input logic rst, input bit do_chk);
    bit push;
    bit pop;
    bit new_len;
    bit new_sof;
    TVALID = v; TDATA = d; TLAST = l; TUSER = u;
    datapath_ready = r; err_clr = c; ARESET = rst;
    @(negedge ACLK);
    if (do_chk) begin
      chk("tready", 64'(TREADY), 64'(tready_m));
      chk("rgb_valid", 64'(rgb_valid), 64'(q_m.size() != 0));
      chk("level", 64'(level), 64'(q_m.size()));
      chk("err_line_len", 64'(err_line_len), 64'(eline_m));
      chk("err_sof", 64'(err_sof), 64'(esof_m));
      if (q_m.size() != 0) chk("head", 64'({rgb_out, rgb_sof, rgb_eol}), 64'(q_m[0]));
    end
    if (v && TREADY && !rst) dut_acc++;
    if (r && rgb_valid && !rst) out_log.push_back(rgb_out);
    @(posedge ACLK);
    if (rst) begin
      q_m.delete();
      tready_m = 1'b0; cnt_m = 0; eline_m = 1'b0; esof_m = 1'b0;
    end else begin
      push = v && tready_m;
      pop  = (q_m.size() != 0) && r;
      new_len = 1'b0;
      new_sof = 1'b0;
      if (pop) void'(q_m.pop_front());
      if (push) begin
        q_m.push_back({d, u, l});
        if (u && cnt_m != 0) begin
          new_sof = 1'b1;
          cnt_m = 0;
        end
        cnt_m++;
        if (l) begin
          if (cnt_m != LINE_W) new_len = 1'b1;
          cnt_m = 0;
        end else if (cnt_m == LINE_W) begin
          new_len = 1'b1;
        end
      end
      eline_m  = new_len | (eline_m & ~c);
      esof_m   = new_sof | (esof_m & ~c);
      tready_m = (q_m.size() < DEPTH);
    end
    #1;
  endtask

  task automatic idle(input logic r, input logic c);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, r, c, 1'b0, 1'b1);
  endtask

  initial begin
    int idx;
    // Reset state
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_rgb_out", 64'(rgb_out), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_tready", 64'(TREADY), 64'h0);
    idle(1'b0, 1'b0);
    chk("tready_rise", 64'(TREADY), 64'h1);

    // Single beat, fall-through with one cycle latency
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("single_valid", 64'(rgb_valid), 64'h1);
    chk("single_data", 64'(rgb_out), 64'hA5A5_0001);
    chk("single_sof", 64'(rgb_sof), 64'h1);
    idle(1'b1, 1'b0);
    chk("single_level0", 64'(level), 64'h0);

    // Backpressure: six beats offered into a four-deep FIFO
    dut_acc = 0;
    out_log.delete();
    idx = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'(idx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (dut_acc >= idx) idx++;
    end
    chk("bp_accepted", 64'(dut_acc), 64'd4);
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_tready", 64'(TREADY), 64'h0);
    for (int i = 0; i < 30 && (idx <= 6 || level != 3'd0); i++) begin
      cycle(idx <= 6, 32'(idx), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (dut_acc >= idx) idx++;
    end
    chk("bp_out_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < out_log.size(); i++) chk("bp_order", 64'(out_log[i]), 64'(i + 1));

    // Simultaneous push and pop at level 2, crossing the pointer wrap
    out_log.delete();
    idx = 100;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'(idx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idx++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(idx), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idx++;
      chk("pp_level", 64'(level), 64'd2);
    end
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    chk("pp_out_count", 64'(out_log.size()), 64'd12);
    for (int i = 0; i < out_log.size(); i++) chk("pp_order", 64'(out_log[i]), 64'(100 + i));

    // Fresh start for the line checker
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b0);

    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'(200 + i), i == 7, i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("line_exact_ok", 64'(err_line_len), 64'h0);

    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'(300 + i), i == 5, i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("line_short_err", 64'(err_line_len), 64'h1);
    idle(1'b1, 1'b1);
    chk("line_clr", 64'(err_line_len), 64'h0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(400 + i), 1'b0, i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 6) chk("ovr_before_8th", 64'(err_line_len), 64'h0);
      if (i == 7) chk("ovr_at_8th", 64'(err_line_len), 64'h1);
    end
    chk("pix_saturate", 64'(dut.pix_cnt_r), 64'd8);
    cycle(1'b1, 32'd410, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    chk("ovr_clr", 64'(err_line_len), 64'h0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(500 + i), i == 9, (i == 0) || (i == 2), 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 1) chk("sof_before", 64'(err_sof), 64'h0);
      if (i == 2) chk("sof_mid_line", 64'(err_sof), 64'h1);
    end
    chk("sof_restart_len_ok", 64'(err_line_len), 64'h0);
    idle(1'b1, 1'b1);
    chk("sof_clr", 64'(err_sof), 64'h0);

    // Reset mid-line with three beats buffered and a flag set
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'(600 + i), 1'b0, (i == 0) || (i == 1), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_level3", 64'(level), 64'd3);
    chk("mid_sof_set", 64'(err_sof), 64'h1);
    cycle(1'b1, 32'd603, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mrst_level", 64'(level), 64'h0);
    chk("mrst_valid", 64'(rgb_valid), 64'h0);
    chk("mrst_tready", 64'(TREADY), 64'h0);
    chk("mrst_err_sof", 64'(err_sof), 64'h0);
    chk("mrst_err_len", 64'(err_line_len), 64'h0);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'(700 + i), i == 7, i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    chk("post_rst_len_ok", 64'(err_line_len), 64'h0);
    chk("post_rst_sof_ok", 64'(err_sof), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
